// File: rtl/jt51_opmix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt51_opmix_pkg
// Purpose  : Shared widths, operator-role encoding and arithmetic helpers for
//            the jt51 operator output mixer.
// Revision : 1.0 - initial release
// ============================================================================
package jt51_opmix_pkg;

    localparam int W_IN  = 14;          // operator sample width (signed)
    localparam int W_OUT = 16;          // output sample width (signed)
    localparam int CH    = 8;           // channels per frame
    localparam int W_CH  = W_IN + 2;    // channel accumulator: up to 4 operators
    localparam int W_FR  = W_IN + 5;    // frame accumulator: up to 8 channel sums

    typedef enum logic [1:0] {
        ROLE_M1 = 2'd0,
        ROLE_M2 = 2'd1,
        ROLE_C1 = 2'd2,
        ROLE_C2 = 2'd3
    } op_role_t;

    // True when the operator in this role is a carrier for the given algorithm.
    function automatic logic is_carrier(input logic [2:0] con, input op_role_t role);
        logic r;
        case (role)
            ROLE_C2: r = 1'b1;
            ROLE_C1: r = (con >= 3'd4);
            ROLE_M2: r = (con >= 3'd5);
            default: r = (con == 3'd7);
        endcase
        return r;
    endfunction

    // Clamp a frame total to the signed output range.
    function automatic logic signed [W_OUT-1:0] sat16(input logic signed [W_FR-1:0] v);
        localparam logic signed [W_FR-1:0] SAT_HI = W_FR'(2**(W_OUT-1) - 1);
        localparam logic signed [W_FR-1:0] SAT_LO = ~SAT_HI;
        logic signed [W_OUT-1:0] r;
        if (v > SAT_HI)
            r = {1'b0, {(W_OUT-1){1'b1}}};
        else if (v < SAT_LO)
            r = {1'b1, {(W_OUT-1){1'b0}}};
        else
            r = v[W_OUT-1:0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt51_opmix_if.sv
`default_nettype none
// ============================================================================
// Module   : jt51_opmix_if
// Purpose  : Operator stream in / stereo sample out bundle of the mixer.
//            master = operator pipeline side, slave = mixer side.
// Revision : 1.0 - initial release
// ============================================================================
interface jt51_opmix_if;
    import jt51_opmix_pkg::*;

    logic                     cen;
    logic                     zero;
    logic signed [W_IN-1:0]   op_in;
    logic                     m1;
    logic                     m2;
    logic                     c1;
    logic                     c2;
    logic [2:0]               con;
    logic [1:0]               rl;
    logic signed [W_OUT-1:0]  left;
    logic signed [W_OUT-1:0]  right;
    logic                     sample_valid;
    logic                     dac_sd;
    logic                     dac_ws;

    modport master (
        output cen, zero, op_in, m1, m2, c1, c2, con, rl,
        input  left, right, sample_valid, dac_sd, dac_ws
    );

    modport slave (
        input  cen, zero, op_in, m1, m2, c1, c2, con, rl,
        output left, right, sample_valid, dac_sd, dac_ws
    );

endinterface
`default_nettype wire

// File: rtl/jt51_opmix_ser.sv
`default_nettype none
// ============================================================================
// Module   : jt51_opmix_ser
// Purpose  : MSB-first serializer of the latched {left,right} stereo word;
//            one bit per slot enable, word select low during the left half.
// Revision : 1.0 - initial release
// ============================================================================
module jt51_opmix_ser
    import jt51_opmix_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 cen_i,
    input  wire logic                 load_i,
    input  wire logic [2*W_OUT-1:0]   word_i,
    output logic                      sd_o,
    output logic                      ws_o
);

    logic [2*W_OUT-1:0] sh_q,      sh_d;
    logic [5:0]         cnt_q,     cnt_d;      // bits still to present
    logic               started_q, started_d;  // keeps ws low until the first word

    // Next state: a load restarts the word, otherwise shift while bits remain.
    always_comb begin
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        started_d = started_q;
        if (load_i) begin
            sh_d      = word_i;
            cnt_d     = 6'(2*W_OUT);
            started_d = 1'b1;
        end else if (cen_i && (cnt_q != 6'd0)) begin
            sh_d  = {sh_q[2*W_OUT-2:0], 1'b0};
            cnt_d = cnt_q - 6'd1;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q      <= '0;
            cnt_q     <= '0;
            started_q <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
        end
    end

    assign sd_o = (cnt_q != 6'd0) ? sh_q[2*W_OUT-1] : 1'b0;
    assign ws_o = started_q && (cnt_q <= 6'(W_OUT));

endmodule
`default_nettype wire

// File: rtl/jt51_sh.sv
`default_nettype none
// ============================================================================
// Module   : jt51_sh
// Purpose  : Clock-enabled shift register of STAGES words of WIDTH bits; used
//            as the per-channel accumulator ring of the mixer.
// Revision : 1.0 - initial release
// ============================================================================
module jt51_sh #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             cen_i,
    input  wire logic [WIDTH-1:0] din_i,
    output logic      [WIDTH-1:0] drop_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // First stage captures the incoming word on every enabled slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stage_q[0] <= '0;
        else if (cen_i)
            stage_q[0] <= din_i;
    end

    for (genvar i = 1; i < STAGES; i++) begin : g_stage
        // Each later stage takes its predecessor's word on every enabled slot.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                stage_q[i] <= '0;
            else if (cen_i)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign drop_o = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/jt51_opmix.sv
`default_nettype none
// ============================================================================
// Module   : jt51_opmix
// Purpose  : Sums carrier operators per channel over a 32-slot frame, routes
//            channel sums to L/R and latches saturated stereo totals once per
//            frame. Optional serial DAC output when JT51_OPMIX_SER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module jt51_opmix
    import jt51_opmix_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    jt51_opmix_if.slave opm
);

    logic                    w_onehot;
    op_role_t                w_role;
    logic signed [W_CH-1:0]  w_contrib;
    logic signed [W_CH-1:0]  w_ring_q;
    logic signed [W_CH-1:0]  w_ring_d;
    logic signed [W_CH-1:0]  w_chsum;
    logic signed [W_FR-1:0]  w_add_l;
    logic signed [W_FR-1:0]  w_add_r;

    logic signed [W_FR-1:0]  facc_l_q, facc_l_d;
    logic signed [W_FR-1:0]  facc_r_q, facc_r_d;
    logic signed [W_OUT-1:0] left_q,   left_d;
    logic signed [W_OUT-1:0] right_q,  right_d;
    logic                    frame_seen_q, frame_seen_d;
    logic                    sample_valid_q, sample_valid_d;

    assign w_onehot = $onehot({opm.c2, opm.c1, opm.m2, opm.m1});

    // Decode the role flags; only meaningful when exactly one flag is set.
    always_comb begin
        w_role = ROLE_C2;
        if (opm.m1)
            w_role = ROLE_M1;
        else if (opm.m2)
            w_role = ROLE_M2;
        else if (opm.c1)
            w_role = ROLE_C1;
    end

    // Contribution, channel running sum and ring write-back for this slot.
    always_comb begin
        w_contrib = '0;
        if (w_onehot && is_carrier(opm.con, w_role))
            w_contrib = W_CH'(opm.op_in);
        w_chsum  = w_ring_q + w_contrib;
        // M1 opens the channel's sum; everything else (including no-op flag
        // combinations, whose contribution is 0) carries the sum forward.
        w_ring_d = (w_onehot && opm.m1) ? w_contrib : w_chsum;
        w_add_l  = '0;
        w_add_r  = '0;
        if (w_onehot && opm.c2) begin
            if (opm.rl[0]) w_add_l = W_FR'(w_chsum);
            if (opm.rl[1]) w_add_r = W_FR'(w_chsum);
        end
    end

    // CH-deep ring: a channel's partial sum re-emerges exactly one role later.
    jt51_sh #(
        .WIDTH  (W_CH),
        .STAGES (CH)
    ) u_ring (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (opm.cen),
        .din_i  (w_ring_d),
        .drop_o (w_ring_q)
    );

    // Frame accumulation and once-per-frame latch of the saturated totals.
    always_comb begin
        facc_l_d       = facc_l_q;
        facc_r_d       = facc_r_q;
        left_d         = left_q;
        right_d        = right_q;
        frame_seen_d   = frame_seen_q;
        sample_valid_d = 1'b0;
        if (opm.cen) begin
            if (opm.zero) begin
                // New frame starts with this slot's contribution, even an
                // out-of-order C2 arriving together with zero.
                facc_l_d     = w_add_l;
                facc_r_d     = w_add_r;
                frame_seen_d = 1'b1;
                // The partial frame before the first zero is not a real frame.
                if (frame_seen_q) begin
                    left_d         = sat16(facc_l_q);
                    right_d        = sat16(facc_r_q);
                    sample_valid_d = 1'b1;
                end
            end else begin
                facc_l_d = facc_l_q + w_add_l;
                facc_r_d = facc_r_q + w_add_r;
            end
        end
    end

    // Mixer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            facc_l_q       <= '0;
            facc_r_q       <= '0;
            left_q         <= '0;
            right_q        <= '0;
            frame_seen_q   <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            facc_l_q       <= facc_l_d;
            facc_r_q       <= facc_r_d;
            left_q         <= left_d;
            right_q        <= right_d;
            frame_seen_q   <= frame_seen_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign opm.left         = left_q;
    assign opm.right        = right_q;
    assign opm.sample_valid = sample_valid_q;

`ifdef JT51_OPMIX_SER_EN
    jt51_opmix_ser u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (opm.cen),
        .load_i (sample_valid_d),
        .word_i ({left_d, right_d}),
        .sd_o   (opm.dac_sd),
        .ws_o   (opm.dac_ws)
    );
`else
    assign opm.dac_sd = 1'b0;
    assign opm.dac_ws = 1'b0;
`endif

endmodule
`default_nettype wire
